// File: rtl/ud_step_generator.sv
// ud_step_generator: turns the raw up/down push buttons into single-cycle
// up_count_enable, down_count_enable and clear strobes for the up/down counter.
// Each button is synchronized (two flops) and debounced. A press gives one step,
// and pressing both buttons gives one clear pulse.
// Optional auto-repeat for held buttons: define UD_AUTO_REPEAT_EN.
// Without it, a press gives exactly one step and HOLD_DELAY/REPEAT_PERIOD are ignored.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no debounced button active, waiting for a press
// UP_HOLD | up stepped once, waiting for release, other button or hold delay
// DN_HOLD | down stepped once, waiting for release, other button or hold delay
// UP_RPT  | up auto-repeating every REPEAT_PERIOD cycles (UD_AUTO_REPEAT_EN)
// DN_RPT  | down auto-repeating every REPEAT_PERIOD cycles (UD_AUTO_REPEAT_EN)
// BOTH    | clear issued, waiting until both buttons are released

module ud_step_generator #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_DELAY      = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int TIMER_BITS      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic up_btn,
    input  logic down_btn,
    output logic up_count_enable,
    output logic down_count_enable,
    output logic clear
);

    localparam int MAX_SPAN = (DEBOUNCE_CYCLES > HOLD_DELAY) ?
                              ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD) :
                              ((HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD);

    // Reject parameter sets the timers cannot represent.
    if ((DEBOUNCE_CYCLES < 2) || (HOLD_DELAY < 2) || (REPEAT_PERIOD < 2) ||
        (MAX_SPAN >= (1 << TIMER_BITS))) begin : g_bad_params
        $error("ud_step_generator: illegal parameter set");
    end

    localparam logic [TIMER_BITS-1:0] DB_LAST  = TIMER_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] ONE      = TIMER_BITS'(1);

`ifdef UD_AUTO_REPEAT_EN
    localparam logic [TIMER_BITS-1:0] HOLD_LAST = TIMER_BITS'(HOLD_DELAY - 1);
    localparam logic [TIMER_BITS-1:0] RPT_LAST  = TIMER_BITS'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_UP_HOLD = 3'd1,
        S_DN_HOLD = 3'd2,
        S_UP_RPT  = 3'd3,
        S_DN_RPT  = 3'd4,
        S_BOTH    = 3'd5
    } state_t;

    logic [TIMER_BITS-1:0] r_timer;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_UP_HOLD = 2'd1,
        S_DN_HOLD = 2'd2,
        S_BOTH    = 2'd3
    } state_t;
`endif

    state_t                r_state;
    logic                  r_up_s1, r_up_s2, r_dn_s1, r_dn_s2;
    logic                  r_db_up, r_db_dn;
    logic [TIMER_BITS-1:0] r_cnt_up, r_cnt_dn;

    // Two-flop synchronizers for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_up_s1 <= 1'b0;
            r_up_s2 <= 1'b0;
            r_dn_s1 <= 1'b0;
            r_dn_s2 <= 1'b0;
        end else begin
            r_up_s1 <= up_btn;
            r_up_s2 <= r_up_s1;
            r_dn_s1 <= down_btn;
            r_dn_s2 <= r_dn_s1;
        end
    end

    // Up debounce: level follows the synchronized input after DEBOUNCE_CYCLES stable mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_up <= '0;
            r_db_up  <= 1'b0;
        end else if (r_up_s2 == r_db_up) begin
            r_cnt_up <= '0;
        end else if (r_cnt_up == DB_LAST) begin
            r_db_up  <= r_up_s2;
            r_cnt_up <= '0;
        end else begin
            r_cnt_up <= r_cnt_up + ONE;
        end
    end

    // Down debounce: same scheme as the up button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_dn <= '0;
            r_db_dn  <= 1'b0;
        end else if (r_dn_s2 == r_db_dn) begin
            r_cnt_dn <= '0;
        end else if (r_cnt_dn == DB_LAST) begin
            r_db_dn  <= r_dn_s2;
            r_cnt_dn <= '0;
        end else begin
            r_cnt_dn <= r_cnt_dn + ONE;
        end
    end

    // Step FSM with registered one-cycle strobes; clear always wins over a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            up_count_enable   <= 1'b0;
            down_count_enable <= 1'b0;
            clear             <= 1'b0;
`ifdef UD_AUTO_REPEAT_EN
            r_timer           <= '0;
`endif
        end else begin
            up_count_enable   <= 1'b0;
            down_count_enable <= 1'b0;
            clear             <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_db_up && r_db_dn) begin
                        clear   <= 1'b1;
                        r_state <= S_BOTH;
                    end else if (r_db_up) begin
                        up_count_enable <= 1'b1;
                        r_state         <= S_UP_HOLD;
`ifdef UD_AUTO_REPEAT_EN
                        r_timer         <= '0;
`endif
                    end else if (r_db_dn) begin
                        down_count_enable <= 1'b1;
                        r_state           <= S_DN_HOLD;
`ifdef UD_AUTO_REPEAT_EN
                        r_timer           <= '0;
`endif
                    end
                end
                S_UP_HOLD: begin
                    if (r_db_dn) begin
                        clear   <= 1'b1;
                        r_state <= S_BOTH;
                    end else if (!r_db_up) begin
                        r_state <= S_IDLE;
                    end
`ifdef UD_AUTO_REPEAT_EN
                    else if (r_timer == HOLD_LAST) begin
                        up_count_enable <= 1'b1;
                        r_timer         <= '0;
                        r_state         <= S_UP_RPT;
                    end else begin
                        r_timer <= r_timer + ONE;
                    end
`endif
                end
                S_DN_HOLD: begin
                    if (r_db_up) begin
                        clear   <= 1'b1;
                        r_state <= S_BOTH;
                    end else if (!r_db_dn) begin
                        r_state <= S_IDLE;
                    end
`ifdef UD_AUTO_REPEAT_EN
                    else if (r_timer == HOLD_LAST) begin
                        down_count_enable <= 1'b1;
                        r_timer           <= '0;
                        r_state           <= S_DN_RPT;
                    end else begin
                        r_timer <= r_timer + ONE;
                    end
`endif
                end
`ifdef UD_AUTO_REPEAT_EN
                S_UP_RPT: begin
                    if (r_db_dn) begin
                        clear   <= 1'b1;
                        r_state <= S_BOTH;
                    end else if (!r_db_up) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == RPT_LAST) begin
                        up_count_enable <= 1'b1;
                        r_timer         <= '0;
                    end else begin
                        r_timer <= r_timer + ONE;
                    end
                end
                S_DN_RPT: begin
                    if (r_db_up) begin
                        clear   <= 1'b1;
                        r_state <= S_BOTH;
                    end else if (!r_db_dn) begin
                        r_state <= S_IDLE;
                    end else if (r_timer == RPT_LAST) begin
                        down_count_enable <= 1'b1;
                        r_timer           <= '0;
                    end else begin
                        r_timer <= r_timer + ONE;
                    end
                end
`endif
                S_BOTH: begin
                    if (!r_db_up && !r_db_dn) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ud_step_generator.sv
// Directed bench for ud_step_generator. Cycle c is the clock period that
// follows edge c-1, where edge 0 is the first edge of each scenario.
module tb_ud_step_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up_btn = 1'b0;
    logic down_btn = 1'b0;
    logic up_count_enable;
    logic down_count_enable;
    logic clear;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int q_up[$];
    int q_dn[$];
    int q_clr[$];

    ud_step_generator dut (
        .clk              (clk),
        .rst              (rst),
        .up_btn           (up_btn),
        .down_btn         (down_btn),
        .up_count_enable  (up_count_enable),
        .down_count_enable(down_count_enable),
        .clear            (clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic due(input int q[$], input int c);
        foreach (q[i]) if (q[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one cycle of inputs, then compare {up, down, clear} mid-cycle.
    task automatic tick(input logic u, input logic d, input logic r, input string name);
        up_btn   = u;
        down_btn = d;
        rst      = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check($sformatf("%s@%0d", name, cyc),
              {29'b0, up_count_enable, down_count_enable, clear},
              {29'b0, due(q_up, cyc), due(q_dn, cyc), due(q_clr, cyc)});
    endtask

    task automatic start(input string name);
        q_up.delete();
        q_dn.delete();
        q_clr.delete();
        tick(1'b0, 1'b0, 1'b1, {name, "_rst"});
        tick(1'b0, 1'b0, 1'b1, {name, "_rst"});
        cyc = 0;
    endtask

    initial begin
        // 1: single step, release, then a re-press from IDLE steps at once
        start("single");
        q_up = '{19, 79};
        for (int c = 0; c < 90; c++) tick((c < 30) || (c >= 60), 1'b0, 1'b0, "single");

        // 2: held down button
        start("hold_dn");
`ifdef UD_AUTO_REPEAT_EN
        q_dn = '{19, 83, 99, 115, 131, 147};
`else
        q_dn = '{19};
`endif
        for (int c = 0; c < 180; c++) tick(1'b0, c < 140, 1'b0, "hold_dn");

        // 3a: short pulses never reach the debounced level
        start("glitch");
        for (int c = 0; c < 60; c++) tick((c < 10) || ((c >= 15) && (c < 25)), 1'b0, 1'b0, "glitch");

        // 3b: 3-cycle bounce then steady high from edge 40
        start("bounce");
        q_up = '{59};
        for (int c = 0; c < 110; c++) tick((c < 40) ? ((c % 6) < 3) : (c < 80), 1'b0, 1'b0, "bounce");

        // 4: up held, down joins at 40 -> clear, releasing down alone does nothing
        start("both");
        q_up  = '{19};
        q_clr = '{59};
        for (int c = 0; c < 240; c++) tick(c < 200, (c >= 40) && (c < 120), 1'b0, "both");

        // 5: reset mid-hold restarts the whole chain
        start("midrst");
`ifdef UD_AUTO_REPEAT_EN
        q_up = '{19, 83, 110};
`else
        q_up = '{19, 110};
`endif
        for (int c = 0; c < 130; c++) tick(1'b1, 1'b0, c == 90, "midrst");

        // 6: both buttons rise on the same edge
        start("simul");
        q_clr = '{19};
        for (int c = 0; c < 80; c++) tick(c < 40, c < 40, 1'b0, "simul");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
